// File: rtl/xyz_pkg.sv
// Shared types, constants and coefficient lookup for the RGB->XYZ sequencer.
// Coefficients are stored in Q0.12 and rescaled to the instance's COEF_FRAC.
package xyz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int                STEP_W    = 4;
    localparam int                COEF_Q    = 12;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(8);

    // Coefficient for one MAC step: rows X,Y,Z in order, columns R,G,B within a row.
    function automatic logic [31:0] coef_scaled(input logic [STEP_W-1:0] step, input int frac);
        logic [31:0] base;
        case (step)
            4'd0:    base = 32'd1679;
            4'd1:    base = 32'd1475;
            4'd2:    base = 32'd737;
            4'd3:    base = 32'd860;
            4'd4:    base = 32'd2908;
            4'd5:    base = 32'd295;
            4'd6:    base = 32'd78;
            4'd7:    base = 32'd492;
            4'd8:    base = 32'd3891;
            default: base = 32'd0;
        endcase
        if (frac >= COEF_Q) begin
            return base << (frac - COEF_Q);
        end
        return base >> (COEF_Q - frac);
    endfunction

    // Colour channel used by a step: 0=R, 1=G, 2=B.
    function automatic logic [1:0] step_col(input logic [STEP_W-1:0] step);
        case (step)
            4'd0, 4'd3, 4'd6: return 2'd0;
            4'd1, 4'd4, 4'd7: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

    // Output row a step contributes to: 0=X, 1=Y, 2=Z.
    function automatic logic [1:0] step_row(input logic [STEP_W-1:0] step);
        case (step)
            4'd0, 4'd1, 4'd2: return 2'd0;
            4'd3, 4'd4, 4'd5: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/xyz_mac.sv
// Shared multiply-accumulate for the XYZ sequencer: 8-bit pixel times unsigned
// Q0.COEF_FRAC coefficient, registered accumulator, rounded row result.
// XYZ_SATURATE_EN defined: row result clamps to 255; otherwise the rounded
// value is truncated to OUT_W bits.
module xyz_mac #(
    parameter int COEF_FRAC = 12,
    parameter int OUT_W     = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [7:0]           pix,
    input  logic [COEF_FRAC-1:0] coef,
    output logic [OUT_W-1:0]     result
);

    localparam int               PROD_W = 8 + COEF_FRAC;
    localparam int               ACC_W  = 10 + COEF_FRAC;
    localparam int               RES_W  = ACC_W - COEF_FRAC;
    localparam logic [ACC_W-1:0] ROUND  = ACC_W'(1) << (COEF_FRAC - 1);

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  sum;

    assign prod = PROD_W'(pix) * PROD_W'(coef);
    // clr starts a new row, so the product replaces rather than adds to the old total.
    assign sum  = (clr ? '0 : acc_q) + ACC_W'(prod);

    // Accumulator register, advanced once per enabled step.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum;
        end
    end

`ifdef XYZ_SATURATE_EN
    logic [RES_W-1:0] row_val;

    assign row_val = RES_W'((sum + ROUND) >> COEF_FRAC);
    assign result  = (row_val > RES_W'(255)) ? OUT_W'(255) : OUT_W'(row_val[7:0]);
`else
    assign result  = OUT_W'((sum + ROUND) >> COEF_FRAC);
`endif

endmodule

// File: rtl/xyz_convert_sequencer.sv
// RGB->XYZ converter controller: captures one pixel, runs nine coefficient
// products through a single xyz_mac, then holds X/Y/Z until out_ready.
// Optional XYZ_SATURATE_EN clamps each row to 255 (handled inside xyz_mac).
module xyz_convert_sequencer
    import xyz_pkg::*;
#(
    parameter int COEF_FRAC = 12,
    parameter int OUT_W     = 9
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       R_in,
    input  logic [7:0]       G_in,
    input  logic [7:0]       B_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] X,
    output logic [OUT_W-1:0] Y,
    output logic [OUT_W-1:0] Z,
    output logic             busy
);

    state_t                 state_q;
    state_t                 state_d;
    logic [STEP_W-1:0]      step_q;
    logic [7:0]             r_q;
    logic [7:0]             g_q;
    logic [7:0]             b_q;
    logic [7:0]             pix;
    logic [COEF_FRAC-1:0]   coef;
    logic [1:0]             col;
    logic [1:0]             row;
    logic                   mac_en;
    logic                   mac_clr;
    logic                   row_end;
    logic [OUT_W-1:0]       row_res;
    logic [OUT_W-1:0]       x_q;
    logic [OUT_W-1:0]       y_q;
    logic [OUT_W-1:0]       z_q;

    assign col     = step_col(step_q);
    assign row     = step_row(step_q);
    assign coef    = COEF_FRAC'(coef_scaled(step_q, COEF_FRAC));
    assign mac_clr = (col == 2'd0);
    assign row_end = mac_en && (col == 2'd2);

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/control decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        state_d  = state_q;
        in_ready = 1'b0;
        mac_en   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Step counter: walks 0..8 while in MAC, parked at 0 otherwise.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            step_q <= '0;
        end else if (state_q == MAC && step_q != LAST_STEP) begin
            step_q <= step_q + STEP_W'(1);
        end else begin
            step_q <= '0;
        end
    end

    // Pixel capture on the accept edge.
    always_ff @(posedge Clk) begin
        // NOTE: pixel registers carry no reset; they are always loaded before the MAC reads them.
        if (state_q == IDLE && in_valid) begin
            r_q <= R_in;
            g_q <= G_in;
            b_q <= B_in;
        end
    end

    // Channel select for the current step.
    always_comb begin
        pix = r_q;
        case (col)
            2'd1:    pix = g_q;
            2'd2:    pix = b_q;
            default: pix = r_q;
        endcase
    end

    xyz_mac #(
        .COEF_FRAC (COEF_FRAC),
        .OUT_W     (OUT_W)
    ) u_mac (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .en     (mac_en),
        .clr    (mac_clr),
        .pix    (pix),
        .coef   (coef),
        .result (row_res)
    );

    // Output registers, each written on the last step of its row.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else if (row_end) begin
            case (row)
                2'd0:    x_q <= row_res;
                2'd1:    y_q <= row_res;
                default: z_q <= row_res;
            endcase
        end
    end

    assign X         = x_q;
    assign Y         = y_q;
    assign Z         = z_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule
